note_recorder: RTL and testbench
================================

# note_recorder

Captures microphone audio from the Audio_Controller input FIFO, measures the fundamental period of the incoming tone by zero-crossing timing, and writes one note word per tempo slot into a note RAM. Each word uses the same 19-bit half-period delay format that the square-wave player consumes, so a recorded tune plays back at the same tempo. The block is the writer side of the note RAM and the consumer side of the audio-in FIFO handshake. It sits beside the player and shares CLOCK_50 and the Audio_Controller instance.

## Interface
Parameters:
- ADDR_W, 10: note RAM address width.
- LAST_LINE, 252: final address written; recording stops after it.
- SLOT_CYCLES, 9200000: CLOCK_50 cycles per note slot.
- HYST, 32'd50000000: zero-crossing hysteresis, signed sample magnitude.
- MIN_PERIOD, 2000: shortest accepted period in cycles; shorter periods are noise.

Ports:
- CLOCK_50, in, 1: system clock.
- resetn, in, 1: asynchronous active-low reset.
- start, in, 1: one-cycle pulse that begins recording.
- audio_in_available, in, 1: input FIFO holds a sample.
- left_channel_audio_in, in, 32: signed sample.
- read_audio_in, out, 1: pops the FIFO.
- wr_addr, out, ADDR_W: note RAM address.
- wr_data, out, 19: note RAM data (half-period delay).
- wren, out, 1: note RAM write enable.
- busy, out, 1: high while recording.
- done, out, 1: high after LAST_LINE is written; held until the next start.

## Operation
- States:
  - IDLE: entered on reset.
  - RECORD: entered from IDLE or DONE on start.
  - DONE: entered after the write to LAST_LINE.
- start is ignored while in RECORD.
- read_audio_in = audio_in_available & (state==RECORD). The sample is consumed in that same cycle. In IDLE and DONE the FIFO is left untouched.
- Sign tracker `pos`, cleared on entry to RECORD:
  - set when sample > +HYST (signed);
  - cleared when sample < −HYST;
  - otherwise holds.
- A rising event is a 0→1 transition of `pos`.
- Period counter (20 bits):
  - increments every cycle in RECORD and saturates at 20'hFFFFF;
  - on a rising event: if a previous event exists and the counter is in [MIN_PERIOD, 20'hFFFFF), latch period = counter and set `pvalid`;
  - the counter resets to 0 on every rising event.
- Slot timer:
  - counts 0..SLOT_CYCLES−1 in RECORD and wraps;
  - sampling continues across slot boundaries without interruption.
- On wrap, the note word is computed as follows:
  - pvalid=0 → 0 (rest);
  - otherwise d = (period>>1) − 1, clamped to 19'h7FFFF.
- The write fires on the cycle following the wrap: wren=1 for one cycle, with wr_addr = current address and wr_data = the word.
- After each write: the address increments and pvalid clears. The latched period is retained only for averaging (see Configuration).
- Write to address LAST_LINE → DONE. busy falls and done rises in the same cycle that wren falls.

## Timing
- Reset values: read_audio_in=0, wren=0, wr_addr=0, wr_data=0, busy=0, done=0, all counters 0, state IDLE.
- Reset is asynchronous. Asserting resetn mid-record drops wren immediately; any partial slot is discarded.
- Registered outputs are wren, wr_addr, wr_data, busy and done. read_audio_in is combinational.
- busy rises 1 cycle after start.
- The first wren occurs SLOT_CYCLES+1 cycles after start.
- A rising event and a slot wrap in the same cycle: the new period is latched first, and the word written uses it.
- audio_in_available arriving in the cycle start is sampled is not consumed.
- wr_addr never exceeds LAST_LINE. It returns to 0 on the next start.

## Configuration
- NOTE_REC_AVG_EN defined:
  - a 4-entry period history is kept per slot;
  - if ≥4 periods were latched in the slot, the word uses the sum>>2 of the last four;
  - otherwise it uses the last period;
  - history clears after each write.
- Undefined: the last latched period is used; no history registers exist.

## Test plan
Sim parameters for all tests: SLOT_CYCLES=100000, LAST_LINE=3. Samples arrive every 1000 cycles.

- Reset and idle: no start, samples offered → read_audio_in=0, wren=0, busy=0 throughout.
- Square tone: samples ±1e9 with sign flip every 10 samples (period 20000) → wren pulses at addresses 0..3 with wr_data=9999; done=1 after address 3.
- Silence and noise: samples constant +1000 (within HYST) → four writes of wr_data=0.
- Clamp and reject:
  - one rising event then sample held positive → 0;
  - flips every sample (period 2000 < MIN_PERIOD+edge) → 0 with MIN_PERIOD=3000.
- Reset mid-record: assert resetn low during slot 1 → wren=0 at once; after release and a new start, the first write goes to address 0.
- NOTE_REC_AVG_EN: periods 20000, 20000, 24000, 24000 within one slot → wr_data=10999; without the macro → 11999.

Source files
------------

// File: rtl/note_recorder_if.sv
// note_recorder_if: audio-in FIFO consumer handshake plus note RAM write port.
// master is the recorder side; slave is the FIFO/RAM environment side.
interface note_recorder_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              audio_in_available;
    logic [31:0]       left_channel_audio_in;
    logic              read_audio_in;
    logic [ADDR_W-1:0] wr_addr;
    logic [18:0]       wr_data;
    logic              wren;

    modport master (
        input  audio_in_available, left_channel_audio_in,
        output read_audio_in, wr_addr, wr_data, wren
    );

    modport slave (
        output audio_in_available, left_channel_audio_in,
        input  read_audio_in, wr_addr, wr_data, wren
    );
endinterface

// File: rtl/note_recorder.sv
// note_recorder: measures tone period by zero-crossing timing and writes one half-period
// delay word per tempo slot into the note RAM. Define NOTE_REC_AVG_EN to average the last four periods.
module note_recorder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned LAST_LINE   = 252,
    parameter int unsigned SLOT_CYCLES = 9200000,
    parameter int          HYST        = 32'd50000000,
    parameter int unsigned MIN_PERIOD  = 2000
) (
    input  logic            CLOCK_50,
    input  logic            resetn,
    input  logic            start,
    note_recorder_if.master aud,
    output logic            busy,
    output logic            done
);
    localparam int unsigned SLOT_W = (SLOT_CYCLES > 1) ? $clog2(SLOT_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, RECORD, DONE} state_t;

    state_t              state;
    logic                pos;
    logic                seen_edge;
    logic                pvalid;
    logic [19:0]         per_cnt;
    logic [SLOT_W-1:0]   slot_cnt;
    logic signed [31:0]  sample;
    logic [19:0]         per_inc;
    logic [19:0]         src;
    logic [19:0]         half_m1;
    logic                rise;
    logic                accept;
    logic                wrap;
    logic                valid;
    logic [18:0]         word;
`ifdef NOTE_REC_AVG_EN
    logic [19:0]         hist   [4];
    logic [19:0]         hist_n [4];
    logic [2:0]          hcnt;
    logic [2:0]          hcnt_n;
    logic [21:0]         sum;
`else
    logic [19:0]         period;
`endif

    assign aud.read_audio_in = aud.audio_in_available & (state == RECORD);
    assign sample            = $signed(aud.left_channel_audio_in);

    // The latch path bypasses the registers so an edge landing on the wrap cycle
    // already feeds this slot's word.
    always_comb begin
        per_inc = (per_cnt == '1) ? per_cnt : per_cnt + 20'd1;
        rise    = aud.read_audio_in && !pos && (sample > HYST);
        accept  = rise && seen_edge && (per_inc >= 20'(MIN_PERIOD)) && (per_inc != '1);
        wrap    = (state == RECORD) && (slot_cnt == SLOT_W'(SLOT_CYCLES - 1));
        valid   = pvalid || accept;
`ifdef NOTE_REC_AVG_EN
        hist_n = hist;
        hcnt_n = hcnt;
        if (accept) begin
            for (int unsigned i = 0; i < 3; i++) hist_n[i] = hist[i + 1];
            hist_n[3] = per_inc;
            hcnt_n    = (hcnt == 3'd4) ? hcnt : hcnt + 3'd1;
        end
        sum = 22'(hist_n[0]) + 22'(hist_n[1]) + 22'(hist_n[2]) + 22'(hist_n[3]);
        src = (hcnt_n == 3'd4) ? 20'(sum >> 2) : hist_n[3];
`else
        src = accept ? per_inc : period;
`endif
        half_m1 = (src >> 1) - 20'd1;
        if (!valid)                    word = '0;
        else if (half_m1 > 20'h7FFFF)  word = '1;
        else                           word = half_m1[18:0];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            aud.wren    <= 1'b0;
            aud.wr_addr <= '0;
            aud.wr_data <= '0;
            pos         <= 1'b0;
            seen_edge   <= 1'b0;
            pvalid      <= 1'b0;
            per_cnt     <= '0;
            slot_cnt    <= '0;
`ifdef NOTE_REC_AVG_EN
            hist        <= '{default: '0};
            hcnt        <= '0;
`else
            period      <= '0;
`endif
        end else begin
            aud.wren <= 1'b0;
            case (state)
                RECORD: begin
                    if (aud.read_audio_in) begin
                        if (sample > HYST)       pos <= 1'b1;
                        else if (sample < -HYST) pos <= 1'b0;
                    end
                    per_cnt  <= rise ? '0 : per_inc;
                    slot_cnt <= wrap ? '0 : slot_cnt + SLOT_W'(1);
                    if (rise) seen_edge <= 1'b1;
`ifdef NOTE_REC_AVG_EN
                    hist <= hist_n;
                    hcnt <= hcnt_n;
`else
                    if (accept) period <= per_inc;
`endif
                    if (wrap) begin
                        aud.wren    <= 1'b1;
                        aud.wr_data <= word;
                        pvalid      <= 1'b0;
`ifdef NOTE_REC_AVG_EN
                        hist        <= '{default: '0};
                        hcnt        <= '0;
`endif
                    end else if (accept) begin
                        pvalid <= 1'b1;
                    end
                    // Address advances as the write pulse ends; the last line ends recording instead.
                    if (aud.wren) begin
                        if (aud.wr_addr == ADDR_W'(LAST_LINE)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            aud.wr_addr <= aud.wr_addr + ADDR_W'(1);
                        end
                    end
                end
                default: begin
                    if (start) begin
                        state       <= RECORD;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        aud.wr_addr <= '0;
                        pos         <= 1'b0;
                        seen_edge   <= 1'b0;
                        pvalid      <= 1'b0;
                        per_cnt     <= '0;
                        slot_cnt    <= '0;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_note_recorder.sv
// tb_note_recorder: directed and randomized recordings checked against an
// event-time reference model of the note words.
module tb_note_recorder;
    localparam int unsigned ADDR_W = 10;
    localparam int unsigned S      = 4000;
    localparam int unsigned LAST   = 3;
    localparam int unsigned MINP   = 300;
    localparam int          HYST   = 50000000;
    localparam int          NEND   = (LAST + 1) * S + 2;
    localparam logic [31:0] POS    = 32'd1000000000;
    localparam logic [31:0] NEG    = 32'hC4653600;

    logic clk = 1'b0;
    logic rst_n;
    logic start;
    logic busy;
    logic done;

    int total = 0;
    int bad   = 0;

    logic        av  [NEND + 1];
    logic [31:0] smp [NEND + 1];
    logic [18:0] exp_word [LAST + 1];

    note_recorder_if #(.ADDR_W(ADDR_W)) aud ();

    note_recorder #(
        .ADDR_W(ADDR_W), .LAST_LINE(LAST), .SLOT_CYCLES(S),
        .HYST(HYST), .MIN_PERIOD(MINP)
    ) dut (
        .CLOCK_50(clk), .resetn(rst_n), .start(start),
        .aud(aud), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic clear_stim();
        for (int c = 0; c <= NEND; c++) begin
            av[c]  = 1'b0;
            smp[c] = '0;
        end
        av[0] = 1'b1;            smp[0] = POS;
        av[NEND - 1] = 1'b1;     smp[NEND - 1] = NEG;
        av[NEND] = 1'b1;         smp[NEND] = POS;
    endtask

    task automatic put(input int c, input logic [31:0] v);
        av[c]  = 1'b1;
        smp[c] = v;
    endtask

    task automatic gen_directed();
        int e0[5] = '{1, 1001, 2001, 3001, S};
        int e3[5] = '{3*S + 101, 3*S + 701, 3*S + 1301, 3*S + 2101, 3*S + 2901};
        clear_stim();
        for (int i = 0; i < 5; i++) begin
            put(e0[i], POS);
            put(e0[i] + 400, NEG);
        end
        for (int j = 0; j < 80; j++) put(S + 2 + 50*j, 32'd1000);
        for (int j = 0; j < 80; j++) put(2*S + 1 + 50*j, (j % 2 == 0) ? POS : NEG);
        for (int i = 0; i < 5; i++) begin
            put(e3[i], POS);
            put(e3[i] + 300, NEG);
        end
    endtask

    function automatic logic [31:0] pick_val(input int unsigned i);
        case (i)
            0: pick_val = POS;
            1: pick_val = NEG;
            2: pick_val = HYST;
            3: pick_val = 32'd0 - 32'(HYST);
            4: pick_val = HYST + 1;
            5: pick_val = 32'd0 - 32'(HYST + 1);
            6: pick_val = 32'd1000;
            default: pick_val = 32'hFFFFFFF9;
        endcase
    endfunction

    task automatic gen_random();
        clear_stim();
        for (int k = 0; k <= int'(LAST); k++) begin
            int unsigned mode = $urandom_range(0, 1);
            int unsigned h    = $urandom_range(2, 12);
            int unsigned g    = $urandom_range(15, 60);
            int unsigned n    = 0;
            logic [31:0] a;
            int c = k * S + 1 + $urandom_range(0, 30);
            if ($urandom_range(0, 3) == 0) a = HYST - 1 + $urandom_range(0, 2);
            else                           a = $urandom_range(HYST + 1, 2000000000);
            while (c <= (k + 1) * int'(S)) begin
                if (mode == 0) begin
                    put(c, ((n / h) % 2 == 0) ? a : 32'd0 - a);
                    c += g;
                end else begin
                    put(c, pick_val($urandom_range(0, 7)));
                    c += $urandom_range(1, 60);
                end
                n++;
            end
        end
    endtask

    // Rising events are timed in cycles from the start pulse; each slot's word comes
    // from the accepted periods whose closing event fell inside that slot.
    task automatic build_model();
        int unsigned q[$];
        bit p = 0;
        bit have = 0;
        int last_ev = 0;
        for (int c = 1; c <= (int'(LAST) + 1) * int'(S); c++) begin
            if (av[c]) begin
                int s = $signed(smp[c]);
                if (s > HYST) begin
                    if (!p) begin
                        if (have) begin
                            int unsigned per = c - last_ev;
                            if (per >= MINP && per < 32'hFFFFF) q.push_back(per);
                        end
                        have    = 1;
                        last_ev = c;
                    end
                    p = 1;
                end else if (s < -HYST) begin
                    p = 0;
                end
            end
            if (c % S == 0) begin
                int unsigned src;
                int unsigned d;
                if (q.size() == 0) begin
                    exp_word[c / S - 1] = '0;
                end else begin
`ifdef NOTE_REC_AVG_EN
                    if (q.size() >= 4) src = (q[$] + q[$-1] + q[$-2] + q[$-3]) / 4;
                    else               src = q[$];
`else
                    src = q[$];
`endif
                    d = src / 2 - 1;
                    exp_word[c / S - 1] = (d > 32'h7FFFF) ? 19'h7FFFF : d[18:0];
                end
                q.delete();
            end
        end
    endtask

    task automatic run_record(input int abort_at);
        logic rec;
        logic wexp;
        int   k;
        build_model();
        for (int c = 0; c <= NEND; c++) begin
            @(posedge clk); #1;
            start = (c == 0);
            aud.audio_in_available    = av[c];
            aud.left_channel_audio_in = smp[c];
            #1;
            rec  = (c >= 1) && (c <= NEND - 1);
            wexp = (c > 1) && ((c - 1) % S == 0);
            k    = (c - 1) / S - 1;
            check("read_audio_in", aud.read_audio_in, av[c] && rec);
            check("wren", aud.wren, wexp);
            if (c >= 1) begin
                check("busy", busy, rec);
                check("done", done, c == NEND);
            end
            if (wexp) begin
                check("wr_addr", aud.wr_addr, k);
                check("wr_data", aud.wr_data, exp_word[k]);
            end
            if (c == NEND) check("wr_addr_end", aud.wr_addr, LAST);
            if (c == abort_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_wren", aud.wren, 0);
                check("rst_busy", busy, 0);
                check("rst_read", aud.read_audio_in, 0);
                check("rst_addr", aud.wr_addr, 0);
                @(negedge clk);
                @(negedge clk);
                rst_n = 1'b1;
                aud.audio_in_available = 1'b0;
                return;
            end
        end
        aud.audio_in_available = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        aud.audio_in_available    = 1'b0;
        aud.left_channel_audio_in = '0;
        #12;
        aud.audio_in_available = 1'b1;
        #1;
        check("reset_read", aud.read_audio_in, 0);
        check("reset_wren", aud.wren, 0);
        check("reset_addr", aud.wr_addr, 0);
        check("reset_data", aud.wr_data, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        #10;
        rst_n = 1'b1;

        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            aud.audio_in_available    = 1'($urandom_range(0, 1));
            aud.left_channel_audio_in = ($urandom_range(0, 1) == 1) ? POS : NEG;
            #1;
            check("idle_read", aud.read_audio_in, 0);
            check("idle_wren", aud.wren, 0);
            check("idle_busy", busy, 0);
        end

        gen_directed();
        run_record(-1);
        gen_random();
        run_record(-1);
        gen_random();
        run_record(S + 1);
        check("post_rst_done", done, 0);
        gen_random();
        run_record(-1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
